// File: rtl/octal_latch_pkg.sv
// Shared types and constants for the octal latch load sequencer.
// Optional feature macro: OCTAL_LATCH_PARITY_EN (adds the D_PAR output).
package octal_latch_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  // Per-bit OE levels of a 74F374: high tri-states the outputs
  localparam logic OE_DISABLED = 1'b1;
  localparam logic OE_ENABLED  = 1'b0;

  // Width of an index/counter able to hold 0..n-1, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/octal_latch_timer.sv
// Loadable down-counter with a zero flag. The sequencer reloads it on every
// state change and uses the zero flag to end SETUP and HOLD dwell periods.
// The default build has no configuration macros in this file.
module octal_latch_timer #(
  parameter int WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Count register: load has priority, otherwise count down and park at zero
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (!zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/octal_latch_sequencer.sv
// Load sequencer for a bank of 74F374-style octal registers. Accepts a
// NUM_REGS-byte word, walks it byte by byte onto the shared D bus with a
// one-cycle LD strobe per register, then enables all register outputs for
// HOLD_CYCLES cycles and pulses DONE.
// Optional feature macro: OCTAL_LATCH_PARITY_EN adds D_PAR (odd parity of D).
module octal_latch_sequencer
  import octal_latch_pkg::*;
#(
  parameter int NUM_REGS     = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [8*NUM_REGS-1:0] IN_DATA,
  input  logic                  ABORT,
  output logic [7:0]            D,
  output logic [NUM_REGS-1:0]   LD,
  output logic [NUM_REGS-1:0]   OE,
  output logic                  BUSY,
  output logic                  DONE
`ifdef OCTAL_LATCH_PARITY_EN
  ,
  output logic                  D_PAR
`endif
);

  localparam int IW      = idx_width(NUM_REGS);
  localparam int MAX_DW  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int TW      = idx_width(MAX_DW);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  state_t                  state, state_next;
  logic [IW-1:0]           idx, idx_next;
  logic [8*NUM_REGS-1:0]   shadow;
  logic                    accept;
  logic                    done_next;
  logic                    tmr_load;
  logic [TW-1:0]           tmr_value;
  logic                    tmr_zero;
  logic [7:0]              sel_byte;
  logic [7:0]              d_next;
  logic [NUM_REGS-1:0]     ld_next;
  logic [NUM_REGS-1:0]     oe_next;

  octal_latch_timer #(
    .WIDTH (TW)
  ) u_timer (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  // Next-state logic: handshake, dwell timing, byte index walk and abort
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    accept     = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (IN_VALID && IN_READY && !ABORT) begin
          accept     = 1'b1;
          idx_next   = '0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (ABORT) begin
          idx_next   = '0;
          state_next = IDLE;
        end else if (tmr_zero) begin
          state_next = STROBE;
        end
      end
      STROBE: begin
        if (ABORT) begin
          idx_next   = '0;
          state_next = IDLE;
        end else if (idx == LAST_IDX) begin
          state_next = HOLD;
        end else begin
          idx_next   = idx + 1'b1;
          state_next = SETUP;
        end
      end
      HOLD: begin
        if (ABORT) begin
          idx_next   = '0;
          state_next = IDLE;
        end else if (tmr_zero) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Timer reload on every state change with the dwell of the state being entered
  always_comb begin
    tmr_load  = (state_next != state);
    tmr_value = '0;
    case (state_next)
      SETUP:   tmr_value = TW'(SETUP_CYCLES - 1);
      HOLD:    tmr_value = TW'(HOLD_CYCLES - 1);
      default: tmr_value = '0;
    endcase
  end

  // Byte mux, LD decoder and OE level for the state being entered
  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx_next == IW'(k)) sel_byte = shadow[8*k +: 8];
    end
    d_next  = '0;
    ld_next = '0;
    if (state_next != IDLE) begin
      // On the accept cycle the shadow is still loading, so take byte 0 directly
      d_next = accept ? IN_DATA[7:0] : sel_byte;
    end
    if (state_next == STROBE) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        ld_next[k] = (idx_next == IW'(k));
      end
    end
    oe_next = (state_next == HOLD) ? {NUM_REGS{OE_ENABLED}} : {NUM_REGS{OE_DISABLED}};
  end

  // State and byte index registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Shadow copy of the accepted word
  // NOTE: pure data storage, only read after a capture, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (accept) shadow <= IN_DATA;
  end

  // Registered outputs, aligned with the state they describe
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      D        <= '0;
      LD       <= '0;
      OE       <= {NUM_REGS{OE_DISABLED}};
      IN_READY <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      D        <= d_next;
      LD       <= ld_next;
      OE       <= oe_next;
      IN_READY <= (state_next == IDLE);
      BUSY     <= (state_next != IDLE);
      DONE     <= done_next;
    end
  end

`ifdef OCTAL_LATCH_PARITY_EN
  // Odd parity of D, registered alongside D
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      D_PAR <= 1'b1;
    end else begin
      D_PAR <= ~^d_next;
    end
  end
`endif

endmodule

// File: tb/tb_octal_latch_sequencer.sv
// Self-checking bench for octal_latch_sequencer: directed scenarios plus
// randomized traffic against a transaction-level schedule model.
module tb_octal_latch_sequencer;

  localparam int N     = 2;
  localparam int S     = 1;
  localparam int H     = 4;
  localparam int TOTAL = N * (S + 1) + H + 1;

  typedef struct packed {
    logic [7:0]   d;
    logic [N-1:0] ld;
    logic [N-1:0] oe;
    logic         busy;
    logic         done;
    logic         ready;
    logic         d_known;
  } exp_t;

  logic           CLK;
  logic           RESET;
  logic           in_valid, in_ready, abort, busy, done;
  logic [8*N-1:0] in_data;
  logic [7:0]     d;
  logic [N-1:0]   ld, oe;

  logic           v1, r1, ab1, busy1, done1;
  logic [7:0]     data1, d1;
  logic [0:0]     ld1, oe1;
`ifdef OCTAL_LATCH_PARITY_EN
  logic           d_par, dpar1;
`endif

  octal_latch_sequencer dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .IN_DATA  (in_data),
    .ABORT    (abort),
    .D        (d),
    .LD       (ld),
    .OE       (oe),
    .BUSY     (busy),
    .DONE     (done)
`ifdef OCTAL_LATCH_PARITY_EN
    ,
    .D_PAR    (d_par)
`endif
  );

  octal_latch_sequencer #(
    .NUM_REGS     (1),
    .SETUP_CYCLES (3),
    .HOLD_CYCLES  (1)
  ) dut1 (
    .CLK      (CLK),
    .RESET    (RESET),
    .IN_VALID (v1),
    .IN_READY (r1),
    .IN_DATA  (data1),
    .ABORT    (ab1),
    .D        (d1),
    .LD       (ld1),
    .OE       (oe1),
    .BUSY     (busy1),
    .DONE     (done1)
`ifdef OCTAL_LATCH_PARITY_EN
    ,
    .D_PAR    (dpar1)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a word accepted at cycle 0 produces a fixed schedule over
  // cycles 1..TOTAL, derived from the per-byte setup/strobe rhythm.
  exp_t           ex;
  bit             in_seq;
  int             off;
  logic [8*N-1:0] word;
  int             n_acc;
  int             n_done_obs;
  int             cyc;
  logic           busy_prev;
  int             rise_a, rise_b;

  function automatic exp_t sched(input int o, input logic [8*N-1:0] w);
    exp_t e;
    int   r, p;
    e         = '0;
    e.oe      = '1;
    e.d_known = 1'b1;
    if (o <= N * (S + 1)) begin
      r      = (o - 1) / (S + 1);
      p      = (o - 1) % (S + 1);
      e.d    = 8'(w >> (8 * r));
      if (p == S) e.ld = N'(1) << r;
      e.busy = 1'b1;
    end else if (o <= N * (S + 1) + H) begin
      e.d    = 8'(w >> (8 * (N - 1)));
      e.oe   = '0;
      e.busy = 1'b1;
    end else begin
      e.done    = 1'b1;
      e.ready   = 1'b1;
      e.d_known = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t idle_exp(input logic known);
    exp_t e;
    e         = '0;
    e.oe      = '1;
    e.ready   = 1'b1;
    e.d_known = known;
    return e;
  endfunction

  task automatic model_step();
    if (in_seq && abort) begin
      in_seq = 1'b0;
      ex     = idle_exp(1'b1);
    end else if (in_seq) begin
      off++;
      ex = sched(off, word);
      if (off == TOTAL) in_seq = 1'b0;
    end else if (in_valid && ex.ready && !abort) begin
      word   = in_data;
      in_seq = 1'b1;
      off    = 1;
      ex     = sched(1, word);
      n_acc++;
    end else begin
      ex = idle_exp(ex.d_known);
    end
  endtask

  task automatic compare_all();
    if (ex.d_known) check("D", d, ex.d);
    check("LD", ld, ex.ld);
    check("OE", oe, ex.oe);
    check("BUSY", busy, ex.busy);
    check("DONE", done, ex.done);
    check("IN_READY", in_ready, ex.ready);
    check("LD_onehot0", $onehot0(ld), 1);
    check("LD_OE_overlap", |(ld & ~oe), 0);
    check("LD1_OE1_overlap", ld1 & ~oe1, 0);
`ifdef OCTAL_LATCH_PARITY_EN
    if (ex.d_known) check("D_PAR", d_par, ~^ex.d);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    compare_all();
    if (done) n_done_obs++;
    if (busy && !busy_prev) begin
      rise_a = rise_b;
      rise_b = cyc;
    end
    busy_prev = busy;
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0;
    abort    = 1'b0;
    v1       = 1'b0;
    ab1      = 1'b0;
    RESET    = 1'b1;
    #1;
    in_seq    = 1'b0;
    ex        = '0;
    ex.oe     = '1;
    ex.d_known = 1'b1;
    busy_prev = 1'b0;
    compare_all();
    repeat (n) begin
      @(posedge CLK);
      #1;
      cyc++;
      compare_all();
    end
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    in_valid = 1'b0; abort = 1'b0; in_data = '0;
    v1 = 1'b0; ab1 = 1'b0; data1 = '0;
    n_acc = 0; n_done_obs = 0; cyc = 0; rise_a = 0; rise_b = 0;

    // 1: reset held three cycles, ready one cycle after release
    do_reset(3);
    check("rst_oe", oe, 2'b11);
    check("rst_ld", ld, 0);
    check("rst_d", d, 0);
    check("rst_ready", in_ready, 0);
    check("rst1_oe", oe1, 1);
    tick();
    check("ready_after_rst", in_ready, 1);
    check("ready1_after_rst", r1, 1);

    // 2: single word with explicit cycle expectations
    in_data  = 16'hA55A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      tick();
      if (k == 2) check("t2_byte0", {d, ld}, {8'h5A, 2'b01});
`ifdef OCTAL_LATCH_PARITY_EN
      if (k == 2) check("t6_par_5a", d_par, 1);
`endif
      if (k == 4) check("t2_byte1", {d, ld}, {8'hA5, 2'b10});
      if (k >= 5 && k <= 8) check("t2_oe_low", oe, 2'b00);
      if (k == 9) check("t2_done_ready", {done, in_ready}, 2'b11);
    end

    // 3: back-to-back with IN_VALID held high
    begin
      int acc0, dn0;
      acc0     = n_acc;
      dn0      = n_done_obs;
      in_data  = 16'h1234;
      in_valid = 1'b1;
      for (int c = 0; c < 4 * TOTAL && (n_done_obs - dn0) < 2; c++) begin
        tick();
        if (n_acc - acc0 == 1) in_data = 16'h5678;
        if (n_acc - acc0 >= 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      check("b2b_dones", n_done_obs - dn0, 2);
      check("b2b_gap", rise_b - rise_a, TOTAL);
    end

    // 4: abort in the second OE-low cycle, then abort racing a valid word in IDLE
    tick();
    in_data  = 16'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 2; k <= 6; k++) tick();
    check("t4_oe_low", oe, 2'b00);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort", {oe, done, in_ready, busy}, {2'b11, 1'b0, 1'b1, 1'b0});
    abort    = 1'b1;
    in_valid = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("t4_no_accept", {busy, in_ready}, 2'b01);
    tick();
    check("t4_still_idle", busy, 0);

    // 5: single-register instance, long setup, short hold
    data1 = 8'hFF;
    v1    = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      v1 = 1'b0;
      check("t5_ld", ld1, (k == 4) ? 1 : 0);
      check("t5_oe", oe1, (k == 5) ? 0 : 1);
      check("t5_done", done1, (k == 6) ? 1 : 0);
      if (k == 4) check("t5_d", d1, 8'hFF);
    end

`ifdef OCTAL_LATCH_PARITY_EN
    // 6: parity of a byte with a single one bit
    in_data  = 16'h0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t6_par_01", d_par, 0);
    for (int k = 3; k <= TOTAL; k++) tick();
`endif

    // Randomized traffic with occasional abort and mid-sequence reset
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset(int'($urandom_range(1, 2)));
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        abort    = ($urandom_range(0, 19) == 0);
        in_data  = 16'($urandom);
        tick();
      end
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    for (int k = 0; k < TOTAL + 1; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
